// File: rtl/ghost_core_p.sv
// ghost_core_p: parametrised Ghost Processor execution core.
// Accepts one instruction {op[3:0], rd, a, b} per valid/ready handshake and
// executes it on a NUM_REGS x DATA_W register file. Single-cycle ops write
// back at the end of EXEC. MUL, shifts and rotates iterate one step per cycle
// in ITER, with the remaining step count visible on count.
// Ports:
//   clock, reset       rising-edge clock, synchronous active-low reset
//   data, instr_valid  instruction word and its valid strobe
//   w                  execution enable; low blocks new accepts only
//   instr_ready        core can accept (IDLE and w)
//   done               one-cycle pulse after an instruction completes
//   busy               instruction in flight (EXEC or ITER)
//   reg_values         flattened register file, R0 in the LSBs
//   count              remaining iterations of the current multi-cycle op
//   carry, overflow    ALU flags
module ghost_core_p #(
  parameter int unsigned  DATA_W   = 4,
  parameter int unsigned  NUM_REGS = 4,
  parameter int unsigned  CNT_W    = $clog2(DATA_W + 1),
  localparam int unsigned RA_W     = $clog2(NUM_REGS),
  localparam int unsigned INSTR_W  = 4 + 3 * RA_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [INSTR_W-1:0]           data,
  input  logic                         instr_valid,
  input  logic                         w,
  output logic                         instr_ready,
  output logic                         done,
  output logic                         busy,
  output logic [NUM_REGS*DATA_W-1:0]   reg_values,
  output logic [CNT_W-1:0]             count,
  output logic                         carry,
  output logic                         overflow
);

  localparam int unsigned PW  = 2 * DATA_W;
  localparam int unsigned MSB = DATA_W - 1;

  localparam logic [3:0] OP_NOP  = 4'd0,  OP_MOVK = 4'd1,  OP_MOVR = 4'd2,
                         OP_INC  = 4'd3,  OP_DECK = 4'd4,  OP_INCK = 4'd5,
                         OP_ADD  = 4'd6,  OP_SUB  = 4'd7,  OP_MUL  = 4'd8,
                         OP_AND  = 4'd9,  OP_OR   = 4'd10, OP_NOT  = 4'd11,
                         OP_SL   = 4'd12, OP_SR   = 4'd13;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, ITER = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   rf [NUM_REGS];
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [PW-1:0]       mc_q, mc_d, prod_q, prod_d, prod_step;
  logic [CNT_W-1:0]    count_d, exec_n, n_shift, n_rot;
  logic                wb_en, flag_en, fin, c_d, v_d, accept;
  logic [DATA_W-1:0]   wb_val;

  // Instruction fields and operands (read from the register file in EXEC)
  logic [3:0]          op;
  logic [RA_W-1:0]     f_rd, f_a, f_b;
  logic [DATA_W-1:0]   ra, rb, rv, k_d;
  logic [31:0]         k_ext;

  assign op    = ir_q[INSTR_W-1 -: 4];
  assign f_rd  = ir_q[3*RA_W-1 -: RA_W];
  assign f_a   = ir_q[2*RA_W-1 -: RA_W];
  assign f_b   = ir_q[RA_W-1:0];
  assign ra    = rf[f_a];
  assign rb    = rf[f_b];
  assign rv    = rf[f_rd];
  assign k_d   = DATA_W'({f_a, f_b});
  assign k_ext = 32'(k_d);

  assign n_shift = (k_ext >= 32'(DATA_W)) ? CNT_W'(DATA_W) : CNT_W'(k_ext);
  assign n_rot   = CNT_W'(k_ext % 32'(DATA_W));

  // Add-type and sub-type datapaths with carry/borrow and signed overflow
  logic [DATA_W-1:0] add_x, add_y, sub_x, sub_y;
  logic [DATA_W:0]   sum, diff;
  logic              add_v, sub_v;

  assign add_x = (op == OP_ADD) ? ra : rv;
  assign add_y = (op == OP_INC) ? DATA_W'(1) : ((op == OP_INCK) ? k_d : rb);
  assign sub_x = (op == OP_DECK) ? rv : ra;
  assign sub_y = (op == OP_DECK) ? k_d : rb;
  assign sum   = {1'b0, add_x} + {1'b0, add_y};
  assign diff  = {1'b0, sub_x} - {1'b0, sub_y};
  assign add_v = (add_x[MSB] == add_y[MSB]) && (sum[MSB] != add_x[MSB]);
  assign sub_v = (sub_x[MSB] != sub_y[MSB]) && (diff[MSB] != sub_x[MSB]);

  // One iteration step: acc holds the shifted value, or the MUL multiplier
  logic [DATA_W-1:0] step_acc;
  logic              step_bit;

  always_comb begin
    step_acc = acc_q;
    step_bit = 1'b0;
    case (op)
      OP_SL:   begin step_bit = acc_q[MSB]; step_acc = acc_q << 1; end
      OP_SR:   begin step_bit = acc_q[0];   step_acc = acc_q >> 1; end
      OP_MUL:  step_acc = acc_q >> 1;
      4'd14:   begin step_bit = acc_q[MSB]; step_acc = {acc_q[DATA_W-2:0], acc_q[MSB]}; end
      4'd15:   begin step_bit = acc_q[0];   step_acc = {acc_q[0], acc_q[MSB:1]}; end
      default: ;
    endcase
  end

  assign prod_step = prod_q + (acc_q[0] ? mc_q : '0);

  assign instr_ready = reset && w && (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    count_d = count;
    acc_d   = acc_q;
    mc_d    = mc_q;
    prod_d  = prod_q;
    wb_en   = 1'b0;
    flag_en = 1'b0;
    fin     = 1'b0;
    wb_val  = '0;
    c_d     = 1'b0;
    v_d     = 1'b0;
    exec_n  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ir_d    = data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        fin     = 1'b1;
        wb_en   = 1'b1;
        flag_en = 1'b1;
        case (op)
          OP_NOP:  begin wb_en = 1'b0; flag_en = 1'b0; end
          OP_MOVK: wb_val = k_d;
          OP_MOVR: wb_val = ra;
          OP_INC, OP_INCK, OP_ADD: begin
            wb_val = sum[MSB:0];
            c_d    = sum[DATA_W];
            v_d    = add_v;
          end
          OP_DECK, OP_SUB: begin
            wb_val = diff[MSB:0];
            c_d    = diff[DATA_W];
            v_d    = sub_v;
          end
          OP_MUL:  exec_n = CNT_W'(DATA_W);
          OP_AND:  wb_val = ra & rb;
          OP_OR:   wb_val = ra | rb;
          OP_NOT:  wb_val = ~rv;
          OP_SL, OP_SR: begin wb_val = rv; exec_n = n_shift; end
          default: begin wb_val = rv; exec_n = n_rot; end
        endcase
        // Zero-length shifts/rotates fall through as a rewrite of rd with flags 0
        if (exec_n != '0) begin
          state_d = ITER;
          fin     = 1'b0;
          wb_en   = 1'b0;
          flag_en = 1'b0;
          count_d = exec_n;
          acc_d   = (op == OP_MUL) ? rb : rv;
          mc_d    = PW'(ra);
          prod_d  = '0;
        end
      end
      ITER: begin
        acc_d   = step_acc;
        mc_d    = mc_q << 1;
        prod_d  = prod_step;
        count_d = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          state_d = IDLE;
          fin     = 1'b1;
          wb_en   = 1'b1;
          flag_en = 1'b1;
          if (op == OP_MUL) begin
            wb_val = prod_step[MSB:0];
            c_d    = |prod_step[PW-1:DATA_W];
            v_d    = |prod_step[PW-1:DATA_W];
          end else begin
            wb_val = step_acc;
            c_d    = step_bit;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath, register file and status registers; reset aborts any op
  always_ff @(posedge clock) begin
    if (!reset) begin
      ir_q     <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      prod_q   <= '0;
      count    <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      ir_q   <= ir_d;
      acc_q  <= acc_d;
      mc_q   <= mc_d;
      prod_q <= prod_d;
      count  <= count_d;
      done   <= fin;
      busy   <= (state_d != IDLE);
      if (wb_en) rf[f_rd] <= wb_val;
      if (flag_en) begin
        carry    <= c_d;
        overflow <= v_d;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_values[g*DATA_W +: DATA_W] = rf[g];
  end

endmodule

// File: tb/tb_ghost_core_p.sv
// Directed self-checking bench for ghost_core_p at default parameters.
module tb_ghost_core_p;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  data;
  logic        instr_valid;
  logic        w;
  logic        instr_ready;
  logic        done;
  logic        busy;
  logic [15:0] reg_values;
  logic [2:0]  count;
  logic        carry;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  ghost_core_p dut (
    .clock       (clock),
    .reset       (reset),
    .data        (data),
    .instr_valid (instr_valid),
    .w           (w),
    .instr_ready (instr_ready),
    .done        (done),
    .busy        (busy),
    .reg_values  (reg_values),
    .count       (count),
    .carry       (carry),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r(input int i);
    return 32'(reg_values[i*4 +: 4]);
  endfunction

  function automatic logic [9:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] a, input logic [1:0] b);
    return {op, rd, a, b};
  endfunction

  // Issue one instruction and wait for its done pulse; lat = edges after accept
  task automatic run(input logic [9:0] iw, output int lat);
    int n;
    n = 0;
    data = iw;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin tick(); n++; end
    if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin tick(); lat++; end
    chk("run_done", 32'(done), 32'd1);
  endtask

  initial begin
    int lat, n, accepts, dones;
    logic acc;
    reset = 1'b0; w = 1'b1; instr_valid = 1'b0; data = '0;

    // Reset state
    tick(); tick();
    chk("rst_regs", 32'(reg_values), 32'd0);
    chk("rst_flags", 32'({carry, overflow}), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done_busy", 32'({done, busy}), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_ready", 32'(instr_ready), 32'd1);

    // MOVK R0, 7 with exact timing
    data = 10'b0001_00_01_11;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("movk_exec_busy", 32'(busy), 32'd1);
    chk("movk_exec_ready", 32'(instr_ready), 32'd0);
    chk("movk_exec_r0", r(0), 32'd0);
    tick();
    chk("movk_r0", r(0), 32'd7);
    chk("movk_done", 32'(done), 32'd1);
    chk("movk_carry", 32'(carry), 32'd0);
    chk("movk_idle", 32'({busy, instr_ready}), 32'b01);
    tick();
    chk("movk_done_pulse", 32'(done), 32'd0);

    // ADD with signed overflow, INC with carry out
    run(ins(4'd1, 2'd1, 2'd1, 2'd3), lat);
    run(ins(4'd1, 2'd2, 2'd0, 2'd1), lat);
    run(ins(4'd6, 2'd3, 2'd1, 2'd2), lat);
    chk("add_r3", r(3), 32'd8);
    chk("add_flags", 32'({carry, overflow}), 32'b01);
    chk("add_lat", 32'(lat), 32'd1);
    run(ins(4'd1, 2'd1, 2'd3, 2'd3), lat);
    run(ins(4'd3, 2'd1, 2'd0, 2'd0), lat);
    chk("inc_r1", r(1), 32'd0);
    chk("inc_flags", 32'({carry, overflow}), 32'b10);

    // MUL 5*3 with count sequence
    run(ins(4'd1, 2'd1, 2'd1, 2'd1), lat);
    run(ins(4'd1, 2'd2, 2'd0, 2'd3), lat);
    data = ins(4'd8, 2'd3, 2'd1, 2'd2);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("mul_exec_ready", 32'(instr_ready), 32'd0);
    chk("mul_exec_count", 32'(count), 32'd0);
    for (int k = 4; k >= 1; k--) begin
      tick();
      chk("mul_count", 32'(count), 32'(k));
      chk("mul_iter_ready", 32'(instr_ready), 32'd0);
    end
    tick();
    chk("mul_r3", r(3), 32'd15);
    chk("mul_done", 32'(done), 32'd1);
    chk("mul_flags", 32'({carry, overflow}), 32'b00);
    chk("mul_end", 32'({instr_ready, count}), 32'b1_000);
    // MUL 5*4 = 20 -> low 4, upper bits nonzero
    run(ins(4'd1, 2'd2, 2'd1, 2'd0), lat);
    run(ins(4'd8, 2'd3, 2'd1, 2'd2), lat);
    chk("mul2_r3", r(3), 32'd4);
    chk("mul2_flags", 32'({carry, overflow}), 32'b11);
    chk("mul2_lat", 32'(lat), 32'd5);

    // Rotates and shifts on R0
    run(ins(4'd1, 2'd0, 2'd2, 2'd1), lat);
    run(ins(4'd14, 2'd0, 2'd0, 2'd1), lat);
    chk("slc_r0", r(0), 32'd3);
    chk("slc_carry", 32'({carry, overflow}), 32'b10);
    chk("slc_lat", 32'(lat), 32'd2);
    run(ins(4'd15, 2'd0, 2'd1, 2'd1), lat);
    chk("src_r0", r(0), 32'd9);
    chk("src_carry", 32'(carry), 32'd1);
    chk("src_lat", 32'(lat), 32'd2);
    run(ins(4'd13, 2'd0, 2'd1, 2'd0), lat);
    chk("sr_r0", r(0), 32'd0);
    chk("sr_carry", 32'(carry), 32'd1);
    chk("sr_lat", 32'(lat), 32'd5);
    run(ins(4'd1, 2'd0, 2'd2, 2'd1), lat);
    run(ins(4'd12, 2'd0, 2'd0, 2'd0), lat);
    chk("sl0_r0", r(0), 32'd9);
    chk("sl0_flags", 32'({carry, overflow}), 32'b00);
    chk("sl0_lat", 32'(lat), 32'd1);

    // w=0 blocks accepts
    w = 1'b0;
    data = ins(4'd1, 2'd0, 2'd1, 2'd1);
    instr_valid = 1'b1;
    repeat (3) tick();
    chk("w0_ready", 32'(instr_ready), 32'd0);
    chk("w0_busy", 32'(busy), 32'd0);
    chk("w0_r0", r(0), 32'd9);
    w = 1'b1;
    #1;
    chk("w1_ready", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("w1_busy", 32'(busy), 32'd1);
    tick();
    chk("w1_r0", r(0), 32'd5);

    // Drop w during MUL: it completes, pending instruction waits for w
    run(ins(4'd1, 2'd2, 2'd0, 2'd3), lat);
    data = ins(4'd8, 2'd3, 2'd1, 2'd2);
    instr_valid = 1'b1;
    tick();
    w = 1'b0;
    data = ins(4'd1, 2'd0, 2'd0, 2'd1);
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("wdrop_done", 32'(done), 32'd1);
    chk("wdrop_r3", r(3), 32'd15);
    tick(); tick();
    chk("wdrop_idle", 32'({busy, instr_ready}), 32'b00);
    chk("wdrop_r0", r(0), 32'd5);
    w = 1'b1;
    #1;
    tick();
    instr_valid = 1'b0;
    chk("wdrop_accept", 32'(busy), 32'd1);
    tick();
    chk("wdrop_r0_new", r(0), 32'd1);

    // Valid held through busy: second instruction accepted exactly once
    accepts = 0;
    dones = 0;
    data = ins(4'd8, 2'd3, 2'd1, 2'd2);
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      acc = instr_valid && instr_ready;
      tick();
      if (done) dones++;
      if (acc) begin
        accepts++;
        if (accepts == 1) data = ins(4'd3, 2'd0, 2'd0, 2'd0);
        else instr_valid = 1'b0;
      end
    end
    chk("hold_accepts", 32'(accepts), 32'd2);
    chk("hold_dones", 32'(dones), 32'd2);
    chk("hold_r0", r(0), 32'd2);
    chk("hold_r3", r(3), 32'd15);

    // Reset mid-MUL aborts with no writeback
    run(ins(4'd1, 2'd0, 2'd3, 2'd3), lat);
    run(ins(4'd3, 2'd0, 2'd0, 2'd0), lat);
    chk("pre_rst_carry", 32'(carry), 32'd1);
    run(ins(4'd1, 2'd3, 2'd0, 2'd0), lat);
    data = ins(4'd8, 2'd3, 2'd1, 2'd2);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n = 0;
    while (count != 3'd2 && n < 20) begin tick(); n++; end
    chk("mid_count", 32'(count), 32'd2);
    reset = 1'b0;
    tick();
    chk("mrst_regs", 32'(reg_values), 32'd0);
    chk("mrst_flags", 32'({carry, overflow}), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_done_busy", 32'({done, busy}), 32'd0);
    reset = 1'b1;
    tick();
    chk("mrst_no_wb", 32'({done, r(3)}), 32'd0);
    run(ins(4'd1, 2'd2, 2'd1, 2'd2), lat);
    chk("post_rst_r2", r(2), 32'd6);
    chk("post_rst_r3", r(3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
